// File: rtl/int2flt_seq.sv
// int2flt_seq: sequential 16-bit signed integer to IEEE-754 half-precision converter.
// The operand is captured on an accepted start, its magnitude is normalized one bit
// per clock, then rounded and packed; a one-cycle done pulse marks the result.
// Optional feature macro: I2F_ROUND_EN
//   defined   -> round-to-nearest-even on the 10-bit mantissa
//   undefined -> truncation (guard/sticky discarded)
module int2flt_seq (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] int_i,
    output logic [15:0] flt_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_s;

    logic [15:0] op_r;
    logic        sign_r;
    logic [15:0] mag_r;
    logic [4:0]  exp_r;
    logic [15:0] flt_r;
    logic        busy_r;
    logic        done_r;

    logic [15:0] mag_s;
    logic [9:0]  mant_s;
    logic [4:0]  exp_rnd_s;

    // Magnitude of a two's-complement value; -32768 maps to 0x8000 without overflow.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        abs16 = v[15] ? (~v + 16'd1) : v;
    endfunction

    // Round-to-nearest-even increment decision for a normalized magnitude.
    function automatic logic rne_inc(input logic [15:0] m);
        rne_inc = m[4] & ((|m[3:0]) | m[5]);
    endfunction

    // Magnitude of the captured operand, used while in LOAD.
    always_comb begin
        mag_s = abs16(op_r);
    end

    // Mantissa rounding / truncation and the exponent carry it may cause.
    always_comb begin
        mant_s    = mag_r[14:5];
        exp_rnd_s = exp_r;
`ifdef I2F_ROUND_EN
        if (rne_inc(mag_r)) begin
            if (mag_r[14:5] == 10'h3FF) begin
                mant_s    = 10'd0;
                exp_rnd_s = exp_r + 5'd1;
            end else begin
                mant_s    = mag_r[14:5] + 10'd1;
                exp_rnd_s = exp_r;
            end
        end else begin
            mant_s    = mag_r[14:5];
            exp_rnd_s = exp_r;
        end
`else
        mant_s    = mag_r[14:5];
        exp_rnd_s = exp_r;
`endif
    end

    // Next-state logic; a normalized magnitude skips NORM entirely.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: begin
                if (mag_s == 16'd0) begin
                    next_s = DONE;
                end else if (mag_s[15]) begin
                    next_s = ROUND;
                end else begin
                    next_s = NORM;
                end
            end
            NORM: begin
                // Look ahead at the bit that becomes the MSB after this shift.
                if (mag_r[14]) begin
                    next_s = ROUND;
                end else begin
                    next_s = NORM;
                end
            end
            ROUND:   next_s = DONE;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Datapath: operand capture, normalization shifts and result packing.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_r   <= 16'd0;
            sign_r <= 1'b0;
            mag_r  <= 16'd0;
            exp_r  <= 5'd0;
            flt_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        op_r <= int_i;
                    end
                end
                LOAD: begin
                    sign_r <= op_r[15];
                    mag_r  <= mag_s;
                    exp_r  <= 5'd30;
                    if (mag_s == 16'd0) begin
                        flt_r <= 16'h0000;
                    end
                end
                NORM: begin
                    mag_r <= {mag_r[14:0], 1'b0};
                    exp_r <= exp_r - 5'd1;
                end
                ROUND: begin
                    flt_r <= {sign_r, exp_rnd_s, mant_s};
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

    // Registered status outputs, derived from the state being entered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s == LOAD) || (next_s == NORM) || (next_s == ROUND);
            done_r <= (next_s == DONE);
        end
    end

    assign flt_o  = flt_r;
    assign busy_o = busy_r;
    assign done_o = done_r;

endmodule
